mem_stage_ctrl: RTL and testbench
=================================

Name: mem_stage_ctrl

Overview:
- MEM-stage sequencer for the LC-3b pipeline; sits directly downstream of EX and consumes the control word's opcode plus the computed effective address and store data.
- Decodes the memory opcodes into data-cache transactions:
  - LDR/STR/TRAP: word access.
  - LDB/STB: byte-lane access.
  - LDI/STI: two-phase indirect access.
- Stalls the pipeline until the sequence completes, then presents load data for writeback.

Parameters:
- LDB_SEXT, 1: 1 = LDB result sign-extended from bit 7; 0 = zero-extended.
- ADDR_WIDTH, 16: address/data width. Only 16 is supported; any other value is an elaboration error.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
- valid  in  1  MEM stage holds a live instruction
- opcode  in  4  LC-3b opcode from control word: LDB=0010, STB=0011, LDR=0110, STR=0111, LDI=1010, STI=1011, TRAP=1111
- addr  in  16  effective address from EX
- sdata  in  16  store source register value
- dmem_rdata  in  16  cache read data, valid when dmem_resp=1
- dmem_resp  in  1  cache completes current transaction (single-cycle pulse)
- dmem_read  out  1  read request, held until dmem_resp
- dmem_write  out  1  write request, held until dmem_resp
- dmem_address  out  16  transaction address
- dmem_wdata  out  16  write data
- dmem_byte_enable  out  2  write lane enables; [0]=low byte, [1]=high byte
- mem_stall  out  1  hold IF/ID/EX and the EX/MEM register
- result  out  16  load/TRAP result to the MEM/WB register
- result_valid  out  1  one-cycle strobe: result is final and the instruction retires
- misaligned  out  1  present only with the optional feature

Behaviour:
- is_mem = valid and opcode in {LDB, STB, LDR, STR, LDI, STI, TRAP}. All other opcodes pass through: no stall, result_valid=0.
- States:
  - IDLE
  - ACC: final access
  - PTR: indirect pointer read
  - DONE
- IDLE + is_mem:
  - Latch opcode, addr, sdata.
  - Next state is PTR for LDI/STI, ACC otherwise.
  - mem_stall=1 combinationally in this same cycle.
- PTR:
  - dmem_read=1, dmem_address={addr[15:1],0}.
  - On dmem_resp: latch ptr={rdata[15:1],0}, go to ACC.
- ACC:
  - Issue the final access; on dmem_resp go to DONE, latching the result for loads.
  - Address: ptr for LDI/STI; {addr[15:1],0} for word ops; addr with bit 0 dropped for byte ops (lane chosen by addr[0]).
  - LDR/LDI/TRAP: dmem_read; result=rdata.
  - LDB: dmem_read; byte = addr[0] ? rdata[15:8] : rdata[7:0]; extension per LDB_SEXT.
  - STR/STI: dmem_write, wdata=sdata, byte_enable=11.
  - STB: dmem_write, wdata={sdata[7:0],sdata[7:0]}, byte_enable = addr[0] ? 10 : 01.
- DONE:
  - mem_stall=0, result_valid=1 (also for stores; result=0 for stores).
  - Unconditionally go to IDLE. The still-present old instruction is never restarted.
- mem_stall = (state ∈ {PTR, ACC}) or (state==IDLE and is_mem).
- Minimum latency: entry cycle + 1 ACC cycle (resp same cycle) + DONE = 3 cycles word op; 4 cycles LDI/STI.
- Request signals:
  - Stable (address/data/enables unchanged) from assertion until dmem_resp.
  - Deasserted in the cycle after resp.
  - Never read and write together.
- dmem_resp outside PTR/ACC is ignored.
- Reset values: state=IDLE; dmem_read=0, dmem_write=0, dmem_address=0, dmem_wdata=0, dmem_byte_enable=00, result=0, result_valid=0, mem_stall=0, misaligned=0.
- Reset mid-transaction: request drops the cycle after rst_n is sampled low; any later resp is ignored.
- valid dropping while busy has no effect: latched values are used.

Optional Feature:
- Macro: MEM_UNALIGNED_CHECK_EN.
- Defined:
  - LDR/STR/LDI/STI/TRAP with addr[0]=1, or an LDI/STI pointer with bit 0=1: skip the offending access and go directly to DONE.
  - misaligned=1 with result_valid in DONE; result=0; no write issued.
- Undefined: bit 0 silently forced to 0; misaligned port absent.

Test Plan:
- LDR addr=0x1000, cache resp 2 cycles later with rdata=0xBEEF -> mem_stall high 4 cycles; result=0xBEEF with result_valid one cycle; dmem_address=0x1000.
- STB addr=0x2003, sdata=0x12A5 -> dmem_write with address 0x2002, wdata=0xA5A5, byte_enable=10; result_valid after resp.
- LDB addr=0x3001, rdata=0x80FF, LDB_SEXT=1 -> result=0xFF80; with LDB_SEXT=0 -> result=0x0080.
- LDI addr=0x4000: first resp rdata=0x5000, second rdata=0x1234 -> read at 0x4000, then read at 0x5000; result=0x1234; STI variant writes sdata to 0x5000 with byte_enable=11.
- rst_n low during ACC with dmem_read=1 -> next cycle dmem_read=0, state IDLE; late dmem_resp produces no result_valid.
- MEM_UNALIGNED_CHECK_EN defined, LDR addr=0x1001 -> no dmem_read; misaligned=1 and result_valid=1 in the third cycle.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// LC-3b MEM-stage sequencer: decodes memory opcodes into data-cache transactions and stalls the pipeline until done.
// Optional feature macro MEM_UNALIGNED_CHECK_EN: misaligned word/pointer accesses are skipped and flagged on `misaligned`.
module mem_stage_ctrl #(
  parameter bit LDB_SEXT   = 1'b1,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid,
  input  logic [3:0]            opcode,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [ADDR_WIDTH-1:0] sdata,
  input  logic [ADDR_WIDTH-1:0] dmem_rdata,
  input  logic                  dmem_resp,
  output logic                  dmem_read,
  output logic                  dmem_write,
  output logic [ADDR_WIDTH-1:0] dmem_address,
  output logic [ADDR_WIDTH-1:0] dmem_wdata,
  output logic [1:0]            dmem_byte_enable,
  output logic                  mem_stall,
  output logic [ADDR_WIDTH-1:0] result,
  output logic                  result_valid
`ifdef MEM_UNALIGNED_CHECK_EN
  ,
  output logic                  misaligned
`endif
);

  localparam logic [3:0] OP_LDB  = 4'b0010;
  localparam logic [3:0] OP_STB  = 4'b0011;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  generate
    if (ADDR_WIDTH != 16) begin : g_width_check
      $error("mem_stage_ctrl: only ADDR_WIDTH=16 is supported");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_PTR  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t                  state_reg, state_next;
  logic [3:0]              opcode_reg, opcode_next;
  logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
  logic [ADDR_WIDTH-1:0]   sdata_reg, sdata_next;
  logic [ADDR_WIDTH-1:0]   ptr_reg, ptr_next;
  logic [ADDR_WIDTH-1:0]   result_reg, result_next;
  logic                    mis_reg, mis_next;

  logic                    is_mem;
  logic                    in_ind;
  logic                    in_word;
  logic                    op_store;
  logic                    op_byte;
  logic                    op_ind;
  logic                    entry_misaligned;
  logic                    ptr_misaligned;
  logic [ADDR_WIDTH-1:0]   word_addr;
  logic [7:0]              rd_lane [2];
  logic [7:0]              ld_byte;
  logic [ADDR_WIDTH-1:0]   ldb_value;
  logic [ADDR_WIDTH-1:0]   load_value;

  // Decode of the incoming control word.
  always_comb begin
    is_mem  = 1'b0;
    in_ind  = 1'b0;
    in_word = 1'b0;
    case (opcode)
      OP_LDB, OP_STB:          is_mem = valid;
      OP_LDR, OP_STR, OP_TRAP: begin is_mem = valid; in_word = 1'b1; end
      OP_LDI, OP_STI:          begin is_mem = valid; in_word = 1'b1; in_ind = 1'b1; end
      default:                 is_mem = 1'b0;
    endcase
  end

  assign op_store = (opcode_reg == OP_STB) || (opcode_reg == OP_STR) || (opcode_reg == OP_STI);
  assign op_byte  = (opcode_reg == OP_LDB) || (opcode_reg == OP_STB);
  assign op_ind   = (opcode_reg == OP_LDI) || (opcode_reg == OP_STI);

`ifdef MEM_UNALIGNED_CHECK_EN
  assign entry_misaligned = in_word && addr[0];
  assign ptr_misaligned   = dmem_rdata[0];
  assign misaligned       = (state_reg == ST_DONE) && mis_reg;
`else
  assign entry_misaligned = 1'b0;
  assign ptr_misaligned   = 1'b0;
`endif

  assign word_addr = {addr_reg[ADDR_WIDTH-1:1], 1'b0};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      assign rd_lane[gi] = dmem_rdata[gi*8 +: 8];
    end
  endgenerate

  assign ld_byte    = addr_reg[0] ? rd_lane[1] : rd_lane[0];
  assign ldb_value  = LDB_SEXT ? {{8{ld_byte[7]}}, ld_byte} : {8'h00, ld_byte};
  assign load_value = op_byte ? ldb_value : dmem_rdata;

  // Request outputs are pure functions of state and latched operands, so they stay stable until resp.
  always_comb begin
    state_next       = state_reg;
    opcode_next      = opcode_reg;
    addr_next        = addr_reg;
    sdata_next       = sdata_reg;
    ptr_next         = ptr_reg;
    result_next      = result_reg;
    mis_next         = mis_reg;
    dmem_read        = 1'b0;
    dmem_write       = 1'b0;
    dmem_address     = '0;
    dmem_wdata       = '0;
    dmem_byte_enable = 2'b00;
    mem_stall        = 1'b0;
    result_valid     = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        if (is_mem) begin
          mem_stall   = 1'b1;
          opcode_next = opcode;
          addr_next   = addr;
          sdata_next  = sdata;
          mis_next    = entry_misaligned;
          state_next  = (in_ind && !entry_misaligned) ? ST_PTR : ST_ACC;
        end
      end
      ST_PTR: begin
        mem_stall    = 1'b1;
        dmem_read    = 1'b1;
        dmem_address = word_addr;
        if (dmem_resp) begin
          ptr_next = {dmem_rdata[ADDR_WIDTH-1:1], 1'b0};
          if (ptr_misaligned) begin
            mis_next    = 1'b1;
            result_next = '0;
            state_next  = ST_DONE;
          end else begin
            state_next = ST_ACC;
          end
        end
      end
      ST_ACC: begin
        mem_stall = 1'b1;
        if (mis_reg) begin
          // Offending access is skipped; spend this cycle then retire with a zero result.
          result_next = '0;
          state_next  = ST_DONE;
        end else begin
          dmem_address = op_ind ? ptr_reg : word_addr;
          if (op_store) begin
            dmem_write       = 1'b1;
            dmem_wdata       = op_byte ? {2{sdata_reg[7:0]}} : sdata_reg;
            dmem_byte_enable = op_byte ? (addr_reg[0] ? 2'b10 : 2'b01) : 2'b11;
          end else begin
            dmem_read = 1'b1;
          end
          if (dmem_resp) begin
            result_next = op_store ? '0 : load_value;
            state_next  = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        result_valid = 1'b1;
        state_next   = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      opcode_reg <= '0;
      addr_reg   <= '0;
      sdata_reg  <= '0;
      ptr_reg    <= '0;
      result_reg <= '0;
      mis_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      opcode_reg <= opcode_next;
      addr_reg   <= addr_next;
      sdata_reg  <= sdata_next;
      ptr_reg    <= ptr_next;
      result_reg <= result_next;
      mis_reg    <= mis_next;
    end
  end

  assign result = result_reg;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed cases plus randomized transactions against a transaction-level model.
module tb_mem_stage_ctrl;

  localparam bit SEXT = 1'b1;
  localparam logic [3:0] LDB = 4'b0010, STB = 4'b0011, LDR = 4'b0110, STR = 4'b0111;
  localparam logic [3:0] LDI = 4'b1010, STI = 4'b1011, TRAP = 4'b1111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic [3:0]  opcode = '0;
  logic [15:0] addr = '0, sdata = '0, dmem_rdata = '0;
  logic        dmem_resp = 1'b0;
  logic        dmem_read, dmem_write, mem_stall, result_valid;
  logic [15:0] dmem_address, dmem_wdata, result;
  logic [1:0]  dmem_byte_enable;
`ifdef MEM_UNALIGNED_CHECK_EN
  localparam bit CHK = 1'b1;
  logic misaligned;
`else
  localparam bit CHK = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_stage_ctrl #(.LDB_SEXT(SEXT), .ADDR_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .opcode(opcode), .addr(addr), .sdata(sdata),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_address(dmem_address), .dmem_wdata(dmem_wdata), .dmem_byte_enable(dmem_byte_enable),
    .mem_stall(mem_stall), .result(result), .result_valid(result_valid)
`ifdef MEM_UNALIGNED_CHECK_EN
    , .misaligned(misaligned)
`endif
  );

  typedef struct {
    bit          wr;
    logic [15:0] a;
    logic [15:0] wd;
    logic [1:0]  be;
    logic [15:0] rd;
    int          dly;
  } acc_t;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic scramble();
    valid  = 1'($urandom);
    opcode = 4'($urandom);
    addr   = 16'($urandom);
    sdata  = 16'($urandom);
  endtask

  function automatic bit is_mem_op(input logic [3:0] op);
    return op == LDB || op == STB || op == LDR || op == STR || op == LDI || op == STI || op == TRAP;
  endfunction

  // One memory instruction: model the expected cache accesses and result, then drive and check cycle by cycle.
  task automatic run_txn(input string nm, input logic [3:0] op, input logic [15:0] a, input logic [15:0] sd,
                         input logic [15:0] rd0, input logic [15:0] rd1, input int d0, input int d1);
    acc_t        q[$];
    acc_t        t;
    bit          is_byte, is_ind, is_store, is_load, mis_entry, mis_ptr;
    logic [15:0] exp_res, r, b;
    is_byte   = (op == LDB) || (op == STB);
    is_ind    = (op == LDI) || (op == STI);
    is_store  = (op == STB) || (op == STR) || (op == STI);
    is_load   = !is_store;
    mis_entry = CHK && !is_byte && a[0];
    mis_ptr   = CHK && is_ind && !a[0] && rd0[0];
    if (!mis_entry) begin
      if (is_ind) begin
        t.wr = 1'b0; t.a = a & 16'hFFFE; t.wd = '0; t.be = 2'b00; t.rd = rd0; t.dly = d0;
        q.push_back(t);
        if (!mis_ptr) begin
          t.wr = is_store; t.a = rd0 & 16'hFFFE; t.wd = sd; t.be = 2'b11; t.rd = rd1; t.dly = d1;
          q.push_back(t);
        end
      end else begin
        t.wr = is_store; t.a = a & 16'hFFFE;
        t.wd = is_byte ? ((sd & 16'h00FF) * 16'h0101) : sd;
        t.be = is_byte ? (a[0] ? 2'b10 : 2'b01) : 2'b11;
        t.rd = rd0; t.dly = d0;
        q.push_back(t);
      end
    end
    exp_res = '0;
    if (!mis_entry && !mis_ptr && is_load) begin
      r = q[q.size()-1].rd;
      if (op == LDB) begin
        b = (r >> (a[0] ? 8 : 0)) & 16'h00FF;
        exp_res = (SEXT && b >= 16'd128) ? (b + 16'hFF00) : b;
      end else begin
        exp_res = r;
      end
    end

    @(negedge clk);
    valid = 1'b1; opcode = op; addr = a; sdata = sd;
    dmem_resp = 1'($urandom); dmem_rdata = 16'($urandom);
    #1;
    check({nm, "/entry_stall"}, 16'(mem_stall), 16'd1);
    check({nm, "/entry_rv"}, 16'(result_valid), 16'd0);
    check({nm, "/entry_req"}, 16'(dmem_read | dmem_write), 16'd0);
    @(posedge clk);
    if (mis_entry) begin
      @(negedge clk);
      scramble(); dmem_resp = 1'b0;
      #1;
      check({nm, "/skip_stall"}, 16'(mem_stall), 16'd1);
      check({nm, "/skip_req"}, 16'(dmem_read | dmem_write), 16'd0);
      @(posedge clk);
    end
    for (int k = 0; k < q.size(); k++) begin
      for (int c = 0; c <= q[k].dly; c++) begin
        @(negedge clk);
        scramble();
        dmem_resp  = (c == q[k].dly);
        dmem_rdata = (c == q[k].dly) ? q[k].rd : 16'($urandom);
        #1;
        check($sformatf("%s/acc%0d_read", nm, k), 16'(dmem_read), 16'(!q[k].wr));
        check($sformatf("%s/acc%0d_write", nm, k), 16'(dmem_write), 16'(q[k].wr));
        check($sformatf("%s/acc%0d_addr", nm, k), dmem_address, q[k].a);
        if (q[k].wr) begin
          check($sformatf("%s/acc%0d_wdata", nm, k), dmem_wdata, q[k].wd);
          check($sformatf("%s/acc%0d_be", nm, k), 16'(dmem_byte_enable), 16'(q[k].be));
        end
        check($sformatf("%s/acc%0d_stall", nm, k), 16'(mem_stall), 16'd1);
        check($sformatf("%s/acc%0d_rv", nm, k), 16'(result_valid), 16'd0);
        @(posedge clk);
      end
    end
    @(negedge clk);
    scramble(); dmem_resp = 1'($urandom); dmem_rdata = 16'($urandom);
    #1;
    check({nm, "/done_rv"}, 16'(result_valid), 16'd1);
    check({nm, "/done_stall"}, 16'(mem_stall), 16'd0);
    check({nm, "/done_result"}, result, exp_res);
    check({nm, "/done_req"}, 16'(dmem_read | dmem_write), 16'd0);
`ifdef MEM_UNALIGNED_CHECK_EN
    check({nm, "/done_mis"}, 16'(misaligned), 16'(mis_entry || mis_ptr));
`endif
    @(posedge clk);
  endtask

  // A cycle with no memory instruction in MEM: must pass straight through, stray resp ignored.
  task automatic run_nonmem(input string nm);
    logic [3:0] op;
    @(negedge clk);
    valid = 1'($urandom);
    op = 4'($urandom);
    while (valid && is_mem_op(op)) op = 4'($urandom);
    opcode = op; addr = 16'($urandom); sdata = 16'($urandom);
    dmem_resp = 1'($urandom); dmem_rdata = 16'($urandom);
    #1;
    check({nm, "/stall"}, 16'(mem_stall), 16'd0);
    check({nm, "/rv"}, 16'(result_valid), 16'd0);
    check({nm, "/req"}, 16'(dmem_read | dmem_write), 16'd0);
    @(posedge clk);
  endtask

  initial begin
    logic [3:0]  mem_ops [7];
    logic [3:0]  op;
    logic [15:0] ra, rd0;
    mem_ops = '{LDB, STB, LDR, STR, LDI, STI, TRAP};

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset/read", 16'(dmem_read), 16'd0);
    check("reset/write", 16'(dmem_write), 16'd0);
    check("reset/addr", dmem_address, 16'h0000);
    check("reset/wdata", dmem_wdata, 16'h0000);
    check("reset/be", 16'(dmem_byte_enable), 16'd0);
    check("reset/result", result, 16'h0000);
    check("reset/rv", 16'(result_valid), 16'd0);
    check("reset/stall", 16'(mem_stall), 16'd0);
`ifdef MEM_UNALIGNED_CHECK_EN
    check("reset/mis", 16'(misaligned), 16'd0);
`endif

    run_txn("ldr", LDR, 16'h1000, 16'h0000, 16'hBEEF, 16'h0000, 2, 0);
    run_txn("stb", STB, 16'h2003, 16'h12A5, 16'h7777, 16'h0000, 1, 0);
    run_txn("ldb", LDB, 16'h3001, 16'h0000, 16'h80FF, 16'h0000, 0, 0);
    run_txn("ldb_lo", LDB, 16'h3000, 16'h0000, 16'h8045, 16'h0000, 1, 0);
    run_txn("ldi", LDI, 16'h4000, 16'h0000, 16'h5000, 16'h1234, 1, 2);
    run_txn("sti", STI, 16'h4000, 16'hCAFE, 16'h5000, 16'h0000, 0, 1);
    run_txn("str", STR, 16'h6002, 16'h9876, 16'h0000, 16'h0000, 3, 0);
    run_txn("trap", TRAP, 16'h0040, 16'h0000, 16'h0200, 16'h0000, 0, 0);
`ifdef MEM_UNALIGNED_CHECK_EN
    run_txn("ldr_mis", LDR, 16'h1001, 16'h0000, 16'hBEEF, 16'h0000, 0, 0);
    run_txn("sti_ptr_mis", STI, 16'h4000, 16'h5555, 16'h5001, 16'h0000, 1, 0);
`else
    run_txn("ldr_odd", LDR, 16'h1001, 16'h0000, 16'hBEEF, 16'h0000, 0, 0);
`endif
    run_nonmem("nonmem");

    // Reset while a read is outstanding; a late resp must not retire anything.
    @(negedge clk);
    valid = 1'b1; opcode = LDR; addr = 16'h1000; dmem_resp = 1'b0;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    #1;
    check("rst_mid/read_before", 16'(dmem_read), 16'd1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_mid/read_after", 16'(dmem_read), 16'd0);
    check("rst_mid/stall_after", 16'(mem_stall), 16'd0);
    check("rst_mid/addr_after", dmem_address, 16'h0000);
    dmem_resp = 1'b1; dmem_rdata = 16'hDEAD;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      dmem_resp = 1'b0;
      #1;
      check($sformatf("rst_mid/late_rv%0d", i), 16'(result_valid), 16'd0);
      check($sformatf("rst_mid/late_req%0d", i), 16'(dmem_read | dmem_write), 16'd0);
      @(posedge clk);
    end

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        run_nonmem($sformatf("rnd%0d_nonmem", n));
      end else begin
        op  = mem_ops[$urandom_range(0, 6)];
        ra  = 16'($urandom);
        rd0 = 16'($urandom);
        run_txn($sformatf("rnd%0d_op%h", n, op), op, ra, 16'($urandom), rd0, 16'($urandom),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end
    end

    @(negedge clk);
    valid = 1'b0; dmem_resp = 1'b0;
    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
